// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster timing source (800x600 @ 60 Hz at
// the default parameters). A pair of 11-bit counters walk the raster, and a
// purely combinational decode of those counters is registered into one
// mutually aligned output bundle (counts, syncs, blanking, frame start).
module vga_timing_gen #(
  parameter int H_ACTIVE  = 800,
  parameter int H_FRONT   = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BACK    = 88,
  parameter int V_ACTIVE  = 600,
  parameter int V_FRONT   = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BACK    = 23,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic        pclk,
  input  logic        rst,
  output logic [10:0] hcount,
  output logic        hsync,
  output logic        hblnk,
  output logic [10:0] vcount,
  output logic        vsync,
  output logic        vblnk,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // 12-bit boundaries so a sync window ending exactly at 2048 still compares
  // correctly against the 11-bit counters.
  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START   = 12'(H_ACTIVE + H_FRONT);
  localparam logic [11:0] HS_END     = 12'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [11:0] VS_START   = 12'(V_ACTIVE + V_FRONT);
  localparam logic [11:0] VS_END     = 12'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic [11:0] h_wide;
  logic [11:0] v_wide;
  logic        h_wrap;
  logic        hs_active;
  logic        vs_active;
  logic        hblnk_d;
  logic        vblnk_d;
  logic        fs_d;

  // Decode of the current counter position; the output registers capture it.
  always_comb begin
    h_wide    = {1'b0, h_cnt};
    v_wide    = {1'b0, v_cnt};
    h_wrap    = (h_wide == H_LAST);
    hblnk_d   = (h_wide >= H_ACT_END);
    vblnk_d   = (v_wide >= V_ACT_END);
    hs_active = (h_wide >= HS_START) && (h_wide < HS_END);
    vs_active = (v_wide >= VS_START) && (v_wide < VS_END);
    fs_d      = (h_cnt == 11'd0) && (v_cnt == 11'd0);
  end

  // Raster counters: the column wraps every line and advances the line count.
  always_ff @(posedge pclk) begin
    if (rst) begin
      h_cnt <= 11'd0;
      v_cnt <= 11'd0;
    end else if (h_wrap) begin
      h_cnt <= 11'd0;
      if (v_wide == V_LAST) begin
        v_cnt <= 11'd0;
      end else begin
        v_cnt <= v_cnt + 11'd1;
      end
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  // Output bundle, all registered together one cycle behind the counters.
  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount      <= 11'd0;
      vcount      <= 11'd0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      frame_start <= 1'b0;
    end else begin
      hcount      <= h_cnt;
      vcount      <= v_cnt;
      hblnk       <= hblnk_d;
      vblnk       <= vblnk_d;
      hsync       <= hs_active ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= vs_active ? VSYNC_POL : ~VSYNC_POL;
      frame_start <= fs_d;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen. Three instances
// share clock and reset: a shrunken raster with active-high syncs (whole
// frames fit in a short run), the same raster with active-low syncs, and the
// default 800x600 timing (exercised across the first lines only).
module tb_vga_timing_gen;

  // Shrunken raster: H 20+4+6+5 = 35, V 10+2+3+4 = 19, frame = 665 cycles.
  localparam int SHA = 20, SHF = 4, SHS = 6, SHB = 5;
  localparam int SVA = 10, SVF = 2, SVS = 3, SVB = 4;
  localparam int S_HT = SHA + SHF + SHS + SHB;
  localparam int S_VT = SVA + SVF + SVS + SVB;
  localparam int S_FRAME = S_HT * S_VT;

  logic pclk = 1'b0;
  logic rst  = 1'b1;

  logic [10:0] hcountS, vcountS, hcountN, vcountN, hcountD, vcountD;
  logic hsyncS, hblnkS, vsyncS, vblnkS, fsS;
  logic hsyncN, hblnkN, vsyncN, vblnkN, fsN;
  logic hsyncD, hblnkD, vsyncD, vblnkD, fsD;

  typedef struct {
    logic [26:0] s;
    logic [26:0] n;
    logic [26:0] d;
  } expT;

  expT sb[$];
  int  checks   = 0;
  int  failures = 0;
  int  n        = 0;
  int  cyc      = 0;
  int  lastFs   = -1;
  int  vsHigh   = 0;
  logic prevVs  = 1'b0;
  bit  prevValid = 1'b0;

  always #5 pclk = ~pclk;

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_ACTIVE(SVA), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dutS (
    .pclk(pclk), .rst(rst), .hcount(hcountS), .hsync(hsyncS), .hblnk(hblnkS),
    .vcount(vcountS), .vsync(vsyncS), .vblnk(vblnkS), .frame_start(fsS)
  );

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_ACTIVE(SVA), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dutN (
    .pclk(pclk), .rst(rst), .hcount(hcountN), .hsync(hsyncN), .hblnk(hblnkN),
    .vcount(vcountN), .vsync(vsyncN), .vblnk(vblnkN), .frame_start(fsN)
  );

  vga_timing_gen dutD (
    .pclk(pclk), .rst(rst), .hcount(hcountD), .hsync(hsyncD), .hblnk(hblnkD),
    .vcount(vcountD), .vsync(vsyncD), .vblnk(vblnkD), .frame_start(fsD)
  );

  // Reference raster: position follows from the number of cycles since reset.
  function automatic logic [26:0] expBundle(input int cnt, input logic inReset,
                                            input int ha, input int hf, input int hs, input int hb,
                                            input int va, input int vf, input int vs, input int vb,
                                            input bit hp, input bit vp);
    int  ht, vt, h, v;
    logic hsA, vsA, hbl, vbl, fs;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    if (inReset) return {11'd0, 11'd0, ~hp, 1'b0, ~vp, 1'b0, 1'b0};
    h   = cnt % ht;
    v   = (cnt / ht) % vt;
    hsA = (h >= ha + hf) && (h < ha + hf + hs);
    vsA = (v >= va + vf) && (v < va + vf + vs);
    hbl = (h >= ha);
    vbl = (v >= va);
    fs  = (h == 0) && (v == 0);
    return {11'(h), 11'(v), hsA ? hp : ~hp, hbl, vsA ? vp : ~vp, vbl, fs};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%h want=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic checkCycle(input logic r);
    expT e;
    e = sb.pop_front();
    checkOutput("bundleS", {5'd0, hcountS, vcountS, hsyncS, hblnkS, vsyncS, vblnkS, fsS}, {5'd0, e.s});
    checkOutput("bundleN", {5'd0, hcountN, vcountN, hsyncN, hblnkN, vsyncN, vblnkN, fsN}, {5'd0, e.n});
    checkOutput("bundleD", {5'd0, hcountD, vcountD, hsyncD, hblnkD, vsyncD, vblnkD, fsD}, {5'd0, e.d});
    if (r) begin
      lastFs    = -1;
      vsHigh    = 0;
      prevValid = 1'b0;
    end else begin
      if (fsS) begin
        if (lastFs >= 0) begin
          checkOutput("fsPeriod", 32'(cyc - lastFs), 32'(S_FRAME));
          checkOutput("vsHighCycles", 32'(vsHigh), 32'(SVS * S_HT));
        end
        lastFs = cyc;
        vsHigh = 0;
      end
      if (vsyncS) vsHigh++;
      if (prevValid && (vsyncS !== prevVs)) checkOutput("vsEdgeAtH0", {21'd0, hcountS}, 32'd0);
      prevVs    = vsyncS;
      prevValid = 1'b1;
    end
  endtask

  // Drive one cycle of reset/run, queue its expected bundles, then compare.
  task automatic applyStimulus(input logic r);
    expT e;
    rst = r;
    e.s = expBundle(n, r, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b1, 1'b1);
    e.n = expBundle(n, r, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b0, 1'b0);
    e.d = expBundle(n, r, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1);
    sb.push_back(e);
    if (r) n = 0;
    else n++;
    @(posedge pclk);
    #1;
    cyc++;
    checkCycle(r);
  endtask

  // Power-up reset, mid-frame 5-cycle reset, long run over several frames,
  // then a single-cycle reset at a chosen raster position and another frame.
  initial begin
    repeat (3) applyStimulus(1'b1);
    repeat (100) applyStimulus(1'b0);
    repeat (5) applyStimulus(1'b1);
    repeat (2 * S_FRAME + 40) applyStimulus(1'b0);
    for (int i = 0; i < S_FRAME; i++) begin
      if ((n % S_HT == 8) && ((n / S_HT) % S_VT == 5)) break;
      applyStimulus(1'b0);
    end
    applyStimulus(1'b1);
    repeat (S_FRAME + 40) applyStimulus(1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
